// File: rtl/mips32_run_ctrl.sv
// Run controller for the mips32 single-cycle core: program load, run/step/halt gating, stop detection.
// Define MIPS32_RUN_CTRL_DUMP_EN to build the register-file/data-memory dump stream.
module mips32_run_ctrl #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_WORDS = 64,
    parameter int MAX_CYCLES = 1024,
    localparam int IA = $clog2(IMEM_DEPTH),
    localparam int DA = $clog2(DMEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_data,
    output logic          imem_we,
    output logic [IA-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst_n,
    output logic          core_en,
    input  logic [31:0]   core_pc,
    input  logic [31:0]   core_instr,
    input  logic          brk_en,
    input  logic [31:0]   brk_addr,
    output logic [4:0]    rf_raddr,
    input  logic [31:0]   rf_rdata,
    output logic [DA-1:0] dm_raddr,
    input  logic [31:0]   dm_rdata,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [31:0]   dump_data,
    output logic          dump_last,
    output logic [2:0]    state,
    output logic [2:0]    halt_cause,
    output logic [31:0]   cycle_count
);

    localparam int PW = IA + 1;
    localparam int RW = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;

    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_CMD      = 3'd1;
    localparam logic [2:0] CAUSE_SENTINEL = 3'd2;
    localparam logic [2:0] CAUSE_BREAK    = 3'd3;
    localparam logic [2:0] CAUSE_END      = 3'd4;
    localparam logic [2:0] CAUSE_WDOG     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_DUMP   = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  prog_len_q, prog_len_d;
    logic [31:0]    cycle_count_q, cycle_count_d;
    logic [2:0]     halt_cause_q, halt_cause_d;
    logic [RW-1:0]  run_count_q, run_count_d;
    logic           first_q, first_d;
    logic           core_rst_n_q;

    logic           cmd_ready_s, ld_ready_s, cmd_fire_s, ld_fire_s;
    logic           active_s, stop_s, core_en_s;
    logic           stop_sentinel_s, stop_brk_s, stop_end_s, stop_wdog_s;
    logic [2:0]     stop_cause_s;
    logic           dump_valid_s, dump_last_s;
    logic           unused_s;

`ifdef MIPS32_RUN_CTRL_DUMP_EN
    localparam int DN = 32 + DMEM_WORDS;
    localparam int DW = $clog2(DN);
    logic [DW-1:0]  dump_idx_q, dump_idx_d;
    logic [DW-1:0]  dump_dm_idx_s;
    state_e         dump_ret_q, dump_ret_d;
    logic           dump_fire_s, dump_is_rf_s;
`endif

    assign active_s    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign cmd_ready_s = (state_q == ST_IDLE) || (state_q == ST_HALTED) || (state_q == ST_RUN);
    assign ld_ready_s  = (state_q == ST_IDLE) && (prog_len_q < PW'(IMEM_DEPTH));
    assign cmd_fire_s  = cmd_valid && cmd_ready_s;
    assign ld_fire_s   = ld_valid && ld_ready_s;

    // Stop detection; the breakpoint is masked on the first cycle after a RUN/STEP accept
    always_comb begin
        stop_sentinel_s = (core_instr == 32'hFFFF_FFFF);
        stop_brk_s      = brk_en && (core_pc == brk_addr) && !first_q;
        stop_end_s      = (core_pc[31:2] >= 30'(prog_len_q));
        stop_wdog_s     = (run_count_q == RW'(MAX_CYCLES));
        if (stop_sentinel_s) begin
            stop_cause_s = CAUSE_SENTINEL;
        end else if (stop_brk_s) begin
            stop_cause_s = CAUSE_BREAK;
        end else if (stop_end_s) begin
            stop_cause_s = CAUSE_END;
        end else if (stop_wdog_s) begin
            stop_cause_s = CAUSE_WDOG;
        end else begin
            stop_cause_s = CAUSE_NONE;
        end
    end

    assign stop_s    = (stop_cause_s != CAUSE_NONE);
    assign core_en_s = active_s && !stop_s;

    // Next-state, program length, counters and halt cause
    always_comb begin
        state_d       = state_q;
        prog_len_d    = prog_len_q;
        cycle_count_d = cycle_count_q;
        halt_cause_d  = halt_cause_q;
        run_count_d   = run_count_q;
        first_d       = first_q;

        if (ld_fire_s) begin
            prog_len_d = prog_len_q + PW'(1);
        end else begin
            prog_len_d = prog_len_q;
        end

        if (core_en_s) begin
            cycle_count_d = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
            run_count_d   = run_count_q + RW'(1);
        end else begin
            cycle_count_d = cycle_count_q;
            run_count_d   = run_count_q;
        end

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (cmd_fire_s) begin
                    case (cmd_op)
                        OP_RUN, OP_STEP: begin
                            state_d     = (cmd_op == OP_RUN) ? ST_RUN : ST_STEP;
                            run_count_d = {RW{1'b0}};
                            first_d     = 1'b1;
                            if (state_q == ST_IDLE) begin
                                cycle_count_d = 32'd0;
                                halt_cause_d  = CAUSE_NONE;
                            end else begin
                                halt_cause_d  = halt_cause_q;
                            end
                        end
`ifdef MIPS32_RUN_CTRL_DUMP_EN
                        2'b11:   state_d = ST_DUMP;
`endif
                        default: state_d = state_q;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                first_d = 1'b0;
                if (stop_s) begin
                    state_d      = ST_HALTED;
                    halt_cause_d = stop_cause_s;
                end else if (cmd_fire_s && (cmd_op == OP_HALT)) begin
                    state_d      = ST_HALTED;
                    halt_cause_d = CAUSE_CMD;
                end else begin
                    state_d      = ST_RUN;
                end
            end
            ST_STEP: begin
                // One enabled cycle at most; a stop here reports its cause, a clean step reports none
                first_d      = 1'b0;
                state_d      = ST_HALTED;
                halt_cause_d = stop_cause_s;
            end
`ifdef MIPS32_RUN_CTRL_DUMP_EN
            ST_DUMP: begin
                if (dump_fire_s && dump_last_s) begin
                    state_d = dump_ret_q;
                end else begin
                    state_d = ST_DUMP;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers; core reset is released whenever the block leaves IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            prog_len_q    <= {PW{1'b0}};
            cycle_count_q <= 32'd0;
            halt_cause_q  <= CAUSE_NONE;
            run_count_q   <= {RW{1'b0}};
            first_q       <= 1'b0;
            core_rst_n_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            prog_len_q    <= prog_len_d;
            cycle_count_q <= cycle_count_d;
            halt_cause_q  <= halt_cause_d;
            run_count_q   <= run_count_d;
            first_q       <= first_d;
            core_rst_n_q  <= (state_d != ST_IDLE);
        end
    end

`ifdef MIPS32_RUN_CTRL_DUMP_EN
    assign dump_valid_s  = (state_q == ST_DUMP);
    assign dump_fire_s   = dump_valid_s && dump_ready;
    assign dump_last_s   = dump_valid_s && (dump_idx_q == DW'(DN - 1));
    assign dump_is_rf_s  = (dump_idx_q < DW'(32));
    assign dump_dm_idx_s = dump_idx_q - DW'(32);

    // Dump index and the state to return to once the stream completes
    always_comb begin
        dump_idx_d = dump_idx_q;
        dump_ret_d = dump_ret_q;
        if (cmd_fire_s && (cmd_op == 2'b11) && ((state_q == ST_IDLE) || (state_q == ST_HALTED))) begin
            dump_idx_d = {DW{1'b0}};
            dump_ret_d = state_q;
        end else if (dump_fire_s && !dump_last_s) begin
            dump_idx_d = dump_idx_q + DW'(1);
        end else begin
            dump_idx_d = dump_idx_q;
        end
    end

    // Dump index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_idx_q <= {DW{1'b0}};
            dump_ret_q <= ST_IDLE;
        end else begin
            dump_idx_q <= dump_idx_d;
            dump_ret_q <= dump_ret_d;
        end
    end

    assign rf_raddr  = dump_is_rf_s ? dump_idx_q[4:0] : 5'd0;
    assign dm_raddr  = dump_is_rf_s ? {DA{1'b0}} : dump_dm_idx_s[DA-1:0];
    assign dump_data = dump_is_rf_s ? rf_rdata : dm_rdata;
    assign unused_s  = ^core_pc[1:0];
`else
    assign dump_valid_s = 1'b0;
    assign dump_last_s  = 1'b0;
    assign rf_raddr     = 5'd0;
    assign dm_raddr     = {DA{1'b0}};
    assign dump_data    = 32'd0;
    assign unused_s     = ^{core_pc[1:0], rf_rdata, dm_rdata, dump_ready};
`endif

    assign cmd_ready   = cmd_ready_s;
    assign ld_ready    = ld_ready_s;
    assign imem_we     = ld_fire_s;
    assign imem_addr   = prog_len_q[IA-1:0];
    assign imem_wdata  = ld_data;
    assign core_rst_n  = core_rst_n_q;
    assign core_en     = core_en_s;
    assign dump_valid  = dump_valid_s;
    assign dump_last   = dump_last_s;
    assign state       = state_q;
    assign halt_cause  = halt_cause_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Directed bench for mips32_run_ctrl with a tiny behavioural core (imem, PC) and fixed rf/dmem patterns.
module tb_mips32_run_ctrl;

    localparam int IMEM_DEPTH = 16;
    localparam int DMEM_WORDS = 8;
    localparam int MAX_CYCLES = 16;
    localparam logic [31:0] LOOP_W = 32'h1000_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = 32'd0;
    logic        brk_en = 1'b0;
    logic [31:0] brk_addr = 32'd0;
    logic        dump_ready = 1'b0;
    logic        cmd_ready, ld_ready, imem_we, core_rst_n, core_en;
    logic        dump_valid, dump_last;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata, core_instr, rf_rdata, dm_rdata, dump_data, cycle_count;
    logic [4:0]  rf_raddr;
    logic [2:0]  dm_raddr, state, halt_cause;

    logic [31:0] imem [16] = '{default: 32'd0};
    logic [31:0] pc = 32'd0;
    int          en_total = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    mips32_run_ctrl #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_WORDS(DMEM_WORDS), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .core_en(core_en), .core_pc(pc), .core_instr(core_instr),
        .brk_en(brk_en), .brk_addr(brk_addr), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dm_raddr(dm_raddr), .dm_rdata(dm_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last), .state(state), .halt_cause(halt_cause),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Behavioural single-cycle core: branch-to-self holds PC, everything else advances by 4
    always @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
        if (!core_rst_n) pc <= 32'd0;
        else if (core_en) pc <= (core_instr == LOOP_W) ? pc : pc + 32'd4;
        if (core_en) en_total <= en_total + 1;
    end

    assign core_instr = imem[pc[5:2]];
    assign rf_rdata   = 32'hA000_0000 | {27'd0, rf_raddr};
    assign dm_rdata   = 32'hD000_0000 | {29'd0, dm_raddr};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_word(input logic [31:0] w, input int idx);
        ld_valid = 1'b1;
        ld_data  = w;
        #1;
        check_vec("ld_we", {31'd0, imem_we}, 32'd1);
        check_vec("ld_addr", {28'd0, imem_addr}, idx);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        for (int i = 0; i < budget && state != 3'd3; i++) tick();
        check_vec(tag, {29'd0, state}, 32'd3);
    endtask

    initial begin
        int e0;
        int k;
        logic [31:0] exp_w;

        // Reset state
        rst_n = 1'b0;
        #2;
        check_vec("rst_state", {29'd0, state}, 32'd0);
        check_vec("rst_cause_cnt", {29'd0, halt_cause} | cycle_count, 32'd0);
        check_vec("rst_outs", {27'd0, core_en, core_rst_n, imem_we, dump_valid, dump_last}, 32'd0);
        check_vec("rst_ready", {30'd0, cmd_ready, ld_ready}, 32'd3);
        tick();
        rst_n = 1'b1;
        tick();

        // Sentinel stop; the sentinel word is loaded in the same cycle RUN is accepted
        load_word(32'h0211_9020, 0);
        load_word(32'h8C0D_0062, 1);
        e0 = en_total;
        ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF; cmd_valid = 1'b1; cmd_op = 2'b00;
        tick();
        ld_valid = 1'b0; cmd_valid = 1'b0;
        check_vec("run_state", {29'd0, state}, 32'd1);
        check_vec("run_corerst", {31'd0, core_rst_n}, 32'd1);
        check_vec("run_en_first", {31'd0, core_en}, 32'd1);
        wait_halt(20, "sent_halt");
        check_vec("sent_en", en_total - e0, 32'd2);
        check_vec("sent_cause", {29'd0, halt_cause}, 32'd2);
        check_vec("sent_cycles", cycle_count, 32'd2);

        // Breakpoint, then resume off it to the program end
        do_reset();
        for (int i = 0; i < 4; i++) load_word(32'h2008_0001 + i, i);
        brk_en = 1'b1; brk_addr = 32'd8;
        e0 = en_total;
        send_cmd(2'b00);
        wait_halt(20, "brk_halt");
        check_vec("brk_pc", pc, 32'd8);
        check_vec("brk_cause", {29'd0, halt_cause}, 32'd3);
        check_vec("brk_cycles", cycle_count, 32'd2);
        send_cmd(2'b00);
        wait_halt(20, "end_halt");
        check_vec("end_pc", pc, 32'd16);
        check_vec("end_cause", {29'd0, halt_cause}, 32'd4);
        check_vec("end_en", en_total - e0, 32'd4);
        check_vec("end_cycles", cycle_count, 32'd4);
        brk_en = 1'b0;

        // Single steps
        do_reset();
        for (int i = 0; i < 5; i++) load_word(32'h2009_0000 + i, i);
        send_cmd(2'b01);
        tick();
        check_vec("step0_pc", pc, 32'd4);
        for (int s = 0; s < 3; s++) begin
            e0 = en_total;
            cmd_valid = 1'b1; cmd_op = 2'b01;
            tick();
            cmd_valid = 1'b0;
            check_vec("step_state", {29'd0, state}, 32'd2);
            check_vec("step_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
            check_vec("step_halted", {29'd0, state}, 32'd3);
            check_vec("step_en", en_total - e0, 32'd1);
            check_vec("step_cause", {29'd0, halt_cause}, 32'd0);
        end
        check_vec("step_pc", pc, 32'd16);
        check_vec("step_cycles", cycle_count, 32'd4);

        // Watchdog on a branch-to-self, then HALT during a second run
        do_reset();
        load_word(LOOP_W, 0);
        e0 = en_total;
        send_cmd(2'b00);
        wait_halt(40, "wd_halt");
        check_vec("wd_en", en_total - e0, 32'd16);
        check_vec("wd_cause", {29'd0, halt_cause}, 32'd5);
        send_cmd(2'b00);
        for (int i = 0; i < 5; i++) tick();
        check_vec("run2_state", {29'd0, state}, 32'd1);
        check_vec("run2_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        e0 = en_total;
        send_cmd(2'b10);
        check_vec("halt_state", {29'd0, state}, 32'd3);
        check_vec("halt_cause", {29'd0, halt_cause}, 32'd1);
        check_vec("halt_last_en", en_total - e0, 32'd1);
        e0 = en_total;
        for (int i = 0; i < 3; i++) tick();
        check_vec("halt_no_en", en_total - e0, 32'd0);
        check_vec("halt_cycles", cycle_count, 32'd22);

        // Dump from HALTED
        send_cmd(2'b11);
`ifdef MIPS32_RUN_CTRL_DUMP_EN
        check_vec("dump_state", {29'd0, state}, 32'd4);
        check_vec("dump_valid_first", {31'd0, dump_valid}, 32'd1);
        k = 0;
        for (int c = 0; c < 200 && k < 40; c++) begin
            dump_ready = c[0];
            #1;
            if (dump_valid && dump_ready) begin
                exp_w = (k < 32) ? (32'hA000_0000 | k) : (32'hD000_0000 | (k - 32));
                check_vec("dump_word", dump_data, exp_w);
                check_vec("dump_last", {31'd0, dump_last}, (k == 39) ? 32'd1 : 32'd0);
                k++;
            end
            @(posedge clk);
            #1;
        end
        dump_ready = 1'b0;
        check_vec("dump_count", k, 32'd40);
        check_vec("dump_return", {29'd0, state}, 32'd3);
`else
        k = 0;
        exp_w = 32'd0;
        check_vec("nodump_state", {29'd0, state}, 32'd3);
        check_vec("nodump_valid", {30'd0, dump_valid, dump_last}, 32'd0);
        check_vec("nodump_data", dump_data, 32'd0);
        check_vec("nodump_addr", {24'd0, rf_raddr, dm_raddr}, 32'd0);
`endif

        // Reset asserted mid-RUN
        send_cmd(2'b00);
        tick();
        check_vec("mid_en", {31'd0, core_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_vec("mid_rst_outs", {29'd0, core_en, dump_valid, core_rst_n}, 32'd0);
        check_vec("mid_rst_state", {29'd0, state}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_vec("mid_rst_prog", {27'd0, ld_ready, imem_addr}, 32'h10);

        // Fill the instruction memory; HALT in IDLE is ignored
        send_cmd(2'b10);
        check_vec("idle_halt_ign", {29'd0, state}, 32'd0);
        for (int i = 0; i < IMEM_DEPTH; i++) load_word(32'h3000_0000 + i, i);
        check_vec("full_ready", {31'd0, ld_ready}, 32'd0);
        ld_valid = 1'b1;
        #1;
        check_vec("full_no_we", {31'd0, imem_we}, 32'd0);
        tick();
        ld_valid = 1'b0;
        check_vec("full_word15", imem[15], 32'h3000_000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips32_run_ctrl.md
# mips32_run_ctrl

Run controller for the mips32 single-cycle core. It loads a program into instruction memory from a host port and holds the core in reset until told to run. It gates the core with a clock enable for run, single-step and halt, and stops on a halt sentinel, breakpoint, program end or watchdog. It then streams the register file and data memory out for result dumping. It sits between the bench/host and the core, replacing hand-driven instruction sequencing.

## Interface
- IMEM_DEPTH, 256: instruction memory words; IA = clog2(IMEM_DEPTH)
- DMEM_WORDS, 64: data memory words dumped; DA = clog2(DMEM_WORDS)
- MAX_CYCLES, 1024: watchdog limit, in enabled cycles per RUN
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_op  in  2  00 RUN, 01 STEP, 10 HALT, 11 DUMP
- ld_valid / ld_ready  in / out  1  program-load handshake
- ld_data  in  32  instruction word
- imem_we, imem_addr, imem_wdata  out  1, IA, 32  instruction memory write port
- core_rst_n  out  1  core reset (low holds PC=0)
- core_en  out  1  core clock enable
- core_pc, core_instr  in  32, 32  current PC and fetched instruction
- brk_en, brk_addr  in  1, 32  breakpoint
- rf_raddr / rf_rdata  out 5 / in 32  register file read (combinational)
- dm_raddr / dm_rdata  out DA / in 32  data memory word read (combinational)
- dump_valid / dump_ready  out / in  1  dump stream handshake
- dump_data, dump_last  out  32, 1  dump word, final-word flag
- state  out  3  0 IDLE, 1 RUN, 2 STEP, 3 HALTED, 4 DUMP
- halt_cause  out  3  0 none, 1 cmd, 2 sentinel, 3 break, 4 end, 5 watchdog
- cycle_count  out  32  enabled-cycle count, saturating

## Operation
- Reset values:
  - state = IDLE; prog_len = 0; cycle_count = 0; halt_cause = 0.
  - core_en = 0; core_rst_n = 0; imem_we = 0; dump_valid = 0; dump_last = 0.
  - cmd_ready = 1; ld_ready = 1.
- core_rst_n is registered and low only in IDLE.
- Load:
  - ld_ready = (state == IDLE) and (prog_len < IMEM_DEPTH).
  - An accepted word drives imem_we = 1, imem_addr = prog_len and imem_wdata = ld_data in the same cycle; prog_len increments.
  - When prog_len reaches IMEM_DEPTH, the block is full and ld_ready = 0.
- cmd_ready = 1 in IDLE, HALTED and RUN; 0 in STEP and DUMP.
- Command acceptance:
  - IDLE/HALTED: RUN goes to RUN, STEP goes to STEP, DUMP goes to DUMP, HALT is ignored.
  - RUN: HALT goes to HALTED with cause 1; all other commands are ignored.
  - RUN or STEP accepted from IDLE clears cycle_count and halt_cause.
- stop = (core_instr == 32'hFFFFFFFF), or (brk_en and core_pc == brk_addr and not first cycle), or (core_pc[31:2] >= prog_len), or (run_count == MAX_CYCLES).
- Cause priority: sentinel > break > end > watchdog.
- core_en = (state is RUN or STEP) and not stop, combinational.
- On stop, the state goes to HALTED at that edge, halt_cause is latched, and the offending instruction is not executed.
- The first cycle after entering RUN/STEP from HALTED ignores the breakpoint, so resuming off a breakpoint works.
- STEP: at most one enabled cycle, then HALTED (cause 0 if no stop).
- run_count clears on every RUN/STEP accept.
- cycle_count increments on every core_en cycle and saturates at 0xFFFFFFFF.
- Dump:
  - Index runs 0..31+DMEM_WORDS.
  - Index < 32: rf_raddr = index, dump_data = rf_rdata.
  - Otherwise: dm_raddr = index-32, dump_data = dm_rdata.
  - dump_valid = 1 throughout DUMP; the index advances on dump_valid & dump_ready.
  - dump_last = 1 on the final index.
  - After the last transfer, the block returns to the state DUMP was entered from (IDLE or HALTED).
- Load and command in the same cycle (IDLE): both take effect; the loaded word counts toward prog_len.

## Timing
- Load: one word per cycle, zero latency to the imem write.
- A RUN accepted at edge N gives core_en at cycle N+1 (core_rst_n rises at the same edge).
- HALT accepted in RUN: the instruction in the accept cycle still executes; core_en = 0 from the next cycle.
- Stop conditions are evaluated combinationally in the same cycle; no instruction past a stop executes.
- Dump: first word valid in the cycle after DUMP is accepted; full throughput of one word per cycle with dump_ready held high.
- Reset asserted mid-RUN/DUMP: core_en and dump_valid drop immediately (asynchronously); the program is discarded (prog_len = 0).

## Configuration
- MIPS32_RUN_CTRL_DUMP_EN:
  - Defined: the DUMP state and dump ports behave as above.
  - Undefined: the DUMP command is accepted and ignored; dump_valid = dump_last = 0; dump_data, rf_raddr and dm_raddr are tied to 0.

## Test plan
- Load 3 words (add s2,s0,s1; lw $13,98($0); 0xFFFFFFFF), then RUN -> core_en high for exactly 2 cycles, state = HALTED, halt_cause = 2, cycle_count = 2.
- Load 4 non-sentinel words, brk_addr = 8, RUN -> halt with PC=8, cause 3, cycle_count = 2. A second RUN -> breakpoint skipped, halt at PC=16 with cause 4.
- From HALTED, STEP three times -> exactly one core_en pulse each, with cmd_ready low during each step.
- Load a branch-to-self loop, MAX_CYCLES = 16, RUN -> halt after 16 enabled cycles, cause 5. HALT during a second RUN -> cause 1, no further enable.
- Fill IMEM_DEPTH words -> ld_ready drops, and a further ld_valid does not assert imem_we.
- DUMP with dump_ready toggling every other cycle -> 32+DMEM_WORDS words in order (rf[0..31], then dmem[0..]), dump_last only on the final word, then state back to HALTED. With the macro undefined -> no dump_valid.
